multu_hilo: RTL and testbench

MULTU_HILO -- requirements
Module: multu_hilo

---
 rtl/multu_hilo.sv | 115 +++++++++++
 tb/tb_multu_hilo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multu_hilo.sv
// rtl/multu_hilo.sv - sequential unsigned multiplier with Hi/Lo result registers
//
// Shift-add multiplier: one partial-product step per clock, WIDTH steps per
// multiply, then a write-back cycle that commits the product to Hi/Lo.
// Requires WIDTH >= 2.
//
// Ports:
//   clk     in   clock, all state on rising edge
//   rst     in   synchronous active-high reset
//   ctrl    in   [5:0] function code (MULTU_OP starts, MFHI_OP/MFLO_OP read)
//   A       in   [WIDTH-1:0] multiplicand, sampled on the start edge
//   B       in   [WIDTH-1:0] multiplier, sampled on the start edge
//   result  out  [WIDTH-1:0] Hi, Lo or 0 depending on ctrl (combinational)
//   busy    out  high while a multiply is in flight (MUL and WB)
//   done    out  one-cycle pulse after Hi/Lo have been written

module multu_hilo #(
    parameter int          WIDTH    = 32,
    parameter logic [5:0]  MULTU_OP = 6'd25,
    parameter logic [5:0]  MFHI_OP  = 6'd16,
    parameter logic [5:0]  MFLO_OP  = 6'd18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [2*WIDTH-1:0]   prod;
    logic [CW-1:0]        cnt;
    logic [WIDTH:0]       upper;

    // Upper half plus optional multiplicand; the extra bit keeps the carry so
    // the shifted-in MSB is exact and the full 2*WIDTH product never overflows.
    always_comb begin
        upper = {1'b0, prod[2*WIDTH-1:WIDTH]};
        if (prod[0]) begin
            upper = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl == MULTU_OP) begin
                        mcand <= A;
                        prod  <= {{WIDTH{1'b0}}, B};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    // Multiplier bits drain out of the bottom while product
                    // bits fill in from the top.
                    prod <= {upper, prod[WIDTH-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= WB;
                    end
                end
                WB: begin
                    hi    <= prod[2*WIDTH-1:WIDTH];
                    lo    <= prod[WIDTH-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Reads only see committed Hi/Lo, never the in-flight prod register.
    always_comb begin
        result = '0;
        if (ctrl == MFHI_OP) begin
            result = hi;
        end else if (ctrl == MFLO_OP) begin
            result = lo;
        end
    end

endmodule

// File: tb/tb_multu_hilo.sv
// tb/tb_multu_hilo.sv - self-checking bench for multu_hilo
module tb_multu_hilo;

    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;
    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam int         LAT      = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ctrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int ntests = 0;
    int nfail  = 0;

    multu_hilo dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl   (ctrl),
        .A      (A),
        .B      (B),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        ctrl = OP_MFHI;
        #1 hi = result;
        ctrl = OP_MFLO;
        #1 lo = result;
        ctrl = OP_NOP;
    endtask

    // Starts a multiply, scrambles A/B right after the start edge, and returns
    // the cycle index (0 = cycle after start edge) at which done is seen.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int busy_cyc);
        @(negedge clk);
        ctrl = OP_MULTU;
        A    = a;
        B    = b;
        @(posedge clk);
        @(negedge clk);
        ctrl = OP_NOP;
        A    = $urandom;
        B    = $urandom;
        lat      = -1;
        busy_cyc = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy) busy_cyc++;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int k = 0; k < limit; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] hi, lo;
        int lat, bc, dcount;
        int rises[$];
        int dones[$];
        logic prev_busy;

        vecs[0] = '{32'd50,        32'd2,        32'h0000_0000, 32'h0000_0064};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[6] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[7] = '{32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000D, 32'hEADB_EEF0};
        vecs[8] = '{32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 32'h0002_0001};
        vecs[9] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};

        // Reset, with a start request held on the reset edges.
        rst  = 1'b1;
        ctrl = OP_MULTU;
        A    = 32'd5;
        B    = 32'd7;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        ctrl = OP_MFHI;
        #1 check("rst_hi", result, 32'd0);
        ctrl = OP_MFLO;
        #1 check("rst_lo", result, 32'd0);
        ctrl = OP_MULTU;
        @(negedge clk);
        check("start_during_rst_ignored", 32'(busy), 32'd0);

        // Start accepted on the very first edge with rst low.
        rst = 1'b0;
        A   = 32'd2;
        B   = 32'd3;
        @(negedge clk);
        ctrl = OP_NOP;
        check("start_after_rst", 32'(busy), 32'd1);
        wait_done(60, lat);
        check("start_after_rst_lat", 32'(lat), 32'(LAT));
        read_hilo(hi, lo);
        check("start_after_rst_lo", lo, 32'd6);

        // Table of directed products.
        for (int i = 0; i < 10; i++) begin
            run_mul(vecs[i].a, vecs[i].b, lat, bc);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(LAT));
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(LAT));
            @(negedge clk);
            check($sformatf("v%0d_done_width", i), 32'(done), 32'd0);
            read_hilo(hi, lo);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            #1 check($sformatf("v%0d_nop_result", i), result, 32'd0);
        end

        // Reset during a multiply aborts it.
        @(negedge clk);
        ctrl = OP_MULTU;
        A    = 32'd7;
        B    = 32'd9;
        @(posedge clk);
        @(negedge clk);
        ctrl = OP_NOP;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        read_hilo(hi, lo);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        run_mul(32'd3, 32'd4, lat, bc);
        check("after_abort_lat", 32'(lat), 32'(LAT));
        read_hilo(hi, lo);
        check("after_abort_lo", lo, 32'd12);

        // Reads during busy return committed values; restart attempts ignored.
        run_mul(32'd50, 32'd2, lat, bc);
        @(negedge clk);
        ctrl = OP_MULTU;
        A    = 32'h0001_0000;
        B    = 32'h0001_0000;
        @(posedge clk);
        @(negedge clk);
        ctrl = OP_NOP;
        A    = 32'd0;
        B    = 32'd0;
        lat  = -1;
        for (int k = 0; k < 100; k++) begin
            if (k == 10) begin
                ctrl = OP_MFHI;
                #1 check("busy_read_hi", result, 32'd0);
                ctrl = OP_MFLO;
                #1 check("busy_read_lo", result, 32'd100);
                ctrl = OP_NOP;
            end
            if (k == 20) begin
                ctrl = OP_MULTU;
                A    = 32'd1;
                B    = 32'd1;
            end
            if (k == 21) ctrl = OP_NOP;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("ignored_restart_lat", 32'(lat), 32'(LAT));
        read_hilo(hi, lo);
        check("ignored_restart_hi", hi, 32'd1);
        check("ignored_restart_lo", lo, 32'd0);

        // Start held high: back-to-back multiplies.
        @(negedge clk);
        ctrl      = OP_MULTU;
        A         = 32'd3;
        B         = 32'd5;
        prev_busy = busy;
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            if (busy && !prev_busy) rises.push_back(t);
            if (done) dones.push_back(t);
            prev_busy = busy;
        end
        ctrl = OP_NOP;
        check("b2b_starts", 32'(rises.size()), 32'd3);
        check("b2b_dones", 32'(dones.size()), 32'd2);
        if (rises.size() >= 2)
            check("b2b_start_spacing", 32'(rises[1] - rises[0]), 32'd34);
        if (dones.size() >= 2)
            check("b2b_done_spacing", 32'(dones[1] - dones[0]), 32'd34);
        if (dones.size() >= 1 && rises.size() >= 1)
            check("b2b_first_latency", 32'(dones[0] - rises[0]), 32'd33);
        wait_done(60, lat);
        check("b2b_final_done_seen", 32'(lat >= 0), 32'd1);
        read_hilo(hi, lo);
        check("b2b_hi", hi, 32'd0);
        check("b2b_lo", lo, 32'd15);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
